// File: rtl/exc_ctrl.sv
// Exception controller: latches per-source requests, vectors Fetch to the
// lowest pending source, preserves return context and restores it on eret.
module exc_ctrl #(
    parameter int          NSRC       = 4,
    parameter int          SW         = 4,
    parameter logic [63:0] VEC_BASE   = 64'hD8,
    parameter logic [63:0] VEC_STRIDE = 64'h80
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] exc_req,
    input  logic            eret,
    input  logic [63:0]     imem_addr_F,
    input  logic [63:0]     next_pc_F,
    input  logic [63:0]     pc_branch_E,
    input  logic [SW-1:0]   estatus,
    input  logic [1:0]      sysreg_sel,
    output logic            redirect,
    output logic [63:0]     exc_vector,
    output logic            exc_ack,
    output logic [63:0]     pc_branch,
    output logic [63:0]     sysreg_rdata,
    output logic            in_handler,
    output logic            overrun
);

    // CAUSE keeps at least one bit so a single-source build still has a register.
    localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VECTOR  = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] pend_next_s;
    logic [NSRC-1:0] clr_s;
    logic [NSRC-1:0] overrun_set_s;
    logic [63:0]     elr_r;
    logic [63:0]     err_r;
    logic [SW-1:0]   esr_r;
    logic [CW-1:0]   cause_r;
    logic [CW-1:0]   sel_s;
    logic            take_s;
    logic            ack_s;
    logic            overrun_r;
    logic [63:0]     vec_s;

    // Lowest set index wins; scanning downward leaves the lowest hit last.
    function automatic logic [CW-1:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Source selection, vector address and acknowledge detection.
    always_comb begin
        take_s = 1'b0;
        sel_s  = lowest_idx(pend_r);
        vec_s  = VEC_BASE + (64'(cause_r) * VEC_STRIDE);
        ack_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            take_s = |pend_r;
        end else begin
            take_s = 1'b0;
        end
        if (state_r == ST_VECTOR) begin
            ack_s = (imem_addr_F == vec_s);
        end else begin
            ack_s = 1'b0;
        end
    end

    // Pending-bit update: a new request on the bit being taken is retained.
    always_comb begin
        clr_s         = {NSRC{1'b0}};
        overrun_set_s = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            clr_s[i] = take_s && (sel_s == CW'(i));
        end
        overrun_set_s = exc_req & pend_r & ~clr_s;
        pend_next_s   = (pend_r & ~clr_s) | exc_req;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_next_s = ST_VECTOR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_VECTOR: begin
                if (ack_s) begin
                    state_next_s = ST_HANDLER;
                end else begin
                    state_next_s = ST_VECTOR;
                end
            end
            ST_HANDLER: begin
                if (eret) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HANDLER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Context registers, pending bits and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r    <= {NSRC{1'b0}};
            elr_r     <= 64'd0;
            err_r     <= 64'd0;
            esr_r     <= {SW{1'b0}};
            cause_r   <= {CW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            pend_r    <= pend_next_s;
            overrun_r <= overrun_r | (|overrun_set_s);
            if (take_s) begin
                elr_r   <= imem_addr_F;
                err_r   <= next_pc_F;
                esr_r   <= estatus;
                cause_r <= sel_s;
            end else begin
                elr_r   <= elr_r;
                err_r   <= err_r;
                esr_r   <= esr_r;
                cause_r <= cause_r;
            end
        end
    end

    // FSM outputs and system-register read mux.
    always_comb begin
        redirect     = (state_r == ST_VECTOR);
        in_handler   = (state_r != ST_IDLE);
        exc_ack      = ack_s;
        exc_vector   = vec_s;
        overrun      = overrun_r;
        pc_branch    = pc_branch_E;
        sysreg_rdata = 64'd0;
        if (eret) begin
            pc_branch = err_r;
        end else begin
            pc_branch = pc_branch_E;
        end
        case (sysreg_sel)
            2'b00:   sysreg_rdata = err_r;
            2'b01:   sysreg_rdata = elr_r;
            2'b10:   sysreg_rdata = 64'(esr_r);
            2'b11:   sysreg_rdata = 64'(cause_r);
            default: sysreg_rdata = 64'd0;
        endcase
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter NSRC, 4, number of exception request sources (1..16).
REQ-002 Parameter SW, 4, exception status width.
REQ-003 Parameter VEC_BASE, 64'hD8, address of vector for source 0.
REQ-004 Parameter VEC_STRIDE, 64'h80, byte distance between consecutive source vectors.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port exc_req  in  NSRC  per-source exception request, level, sampled each clk.
REQ-008 Port eret  in  1  exception-return instruction in Execute.
REQ-009 Port imem_addr_F  in  64  current Fetch PC.
REQ-010 Port next_pc_F  in  64  next sequential Fetch PC.
REQ-011 Port pc_branch_E  in  64  normal branch target from Execute.
REQ-012 Port estatus  in  SW  status to preserve on entry.
REQ-013 Port sysreg_sel  in  2  system-register read select.
REQ-014 Port redirect  out  1  request Fetch to jump to exc_vector.
REQ-015 Port exc_vector  out  64  vector address of the active exception.
REQ-016 Port exc_ack  out  1  one-cycle pulse: Fetch reached exc_vector.
REQ-017 Port pc_branch  out  64  branch target to Fetch.
REQ-018 Port sysreg_rdata  out  64  saved-context read data.
REQ-019 Port in_handler  out  1  handler executing; exceptions masked.
REQ-020 Port overrun  out  1  sticky: request arrived on an already-pending source.

Function
REQ-021 The block SHALL hold pending bits pend[NSRC-1:0]; pend[i] is set in any cycle exc_req[i]=1.
REQ-022 The FSM SHALL have states IDLE, VECTOR, HANDLER.
REQ-023 In IDLE with pend!=0, the block SHALL select the lowest set index k and, on that edge, load ELR<=imem_addr_F, ERR<=next_pc_F, ESR<=estatus, CAUSE<=k, clear pend[k], and enter VECTOR.
REQ-024 exc_vector SHALL equal VEC_BASE + CAUSE*VEC_STRIDE, computed in 64 bits with modulo-2^64 wrap.
REQ-025 redirect SHALL be 1 exactly while in VECTOR.
REQ-026 In VECTOR, when imem_addr_F==exc_vector, exc_ack SHALL be 1 combinationally that cycle and the FSM SHALL enter HANDLER next edge; otherwise it remains in VECTOR.
REQ-027 exc_ack SHALL be 0 in IDLE and HANDLER regardless of imem_addr_F.
REQ-028 in_handler SHALL be 1 in VECTOR and HANDLER; no new exception is selected and ELR/ERR/ESR/CAUSE hold while in_handler=1.
REQ-029 In HANDLER with eret=1, the FSM SHALL enter IDLE next edge; a pending request is then taken no earlier than the following edge.
REQ-030 eret in IDLE or VECTOR SHALL not change state.
REQ-031 pc_branch SHALL be ERR when eret=1, else pc_branch_E, combinational, in every state.
REQ-032 sysreg_rdata SHALL be ERR (00), ELR (01), zero-extended ESR (10), zero-extended CAUSE (11).
REQ-033 Set of pend[k] SHALL win over its clear in the same cycle (request retained).
REQ-034 overrun SHALL set when exc_req[i]=1 while pend[i]=1 and not being cleared that cycle; cleared only by reset.
REQ-035 With NSRC=1, CAUSE SHALL always be 0 and behaviour SHALL match the single-source case.

Reset
REQ-036 With reset=1 at an edge, state SHALL become IDLE; pend, ELR, ERR, ESR, CAUSE, overrun SHALL become 0, from any state including mid-VECTOR.
REQ-037 During and after reset: redirect=0, exc_ack=0, in_handler=0, exc_vector=VEC_BASE, sysreg_rdata per REQ-032 on zeroed registers; exc_req sampled during reset is discarded.

Verification
REQ-038 exc_req=4'b0100 one cycle, imem_addr_F=0x40, next_pc_F=0x44, estatus=5 -> next cycle redirect=1, exc_vector=0x1D8; sel 00/01/10/11 read 0x44/0x40/5/2.
REQ-039 exc_req=4'b1010 same cycle -> source 1 taken (vector 0x158); after eret, source 3 taken (vector 0x258) two edges after eret.
REQ-040 VECTOR with imem_addr_F=0x1D8 -> exc_ack=1 one cycle, in_handler stays 1; eret=1, pc_branch_E=0x900 -> pc_branch=0x44; eret=0 -> pc_branch=0x900.
REQ-041 exc_req[0] asserted twice while handling source 0 -> overrun=1 and one further entry for source 0 after eret.
REQ-042 reset asserted in VECTOR -> next cycle redirect=0, in_handler=0, all sysreg reads 0, overrun=0.
REQ-043 Randomised exc_req/eret 10k cycles against reference model -> no request lost, priority and vector always match.
